// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline control block.
//   pipe_state_t    : sequencer state (RUN, MD_BUSY)
//   MUL_CYCLES_DEF  : default EX occupancy of a multiply
//   DIV_CYCLES_DEF  : default EX occupancy of a divide
//   md_cnt_width()  : width of the mul/div latency counter for a given pair of latencies
package cpu_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } pipe_state_t;

  localparam int MUL_CYCLES_DEF = 3;
  localparam int DIV_CYCLES_DEF = 34;

  // The counter is loaded with (latency - 1), so ceil(log2(latency)) bits hold
  // it; the larger latency sets the width and a 1-cycle latency still needs 1 bit.
  function automatic int md_cnt_width(input int mul_cycles, input int div_cycles);
    int m;
    m = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
//   clk_i : clock
//   rst_i : synchronous active-high reset, clears the count
//   inc_i : count this cycle
//   cnt_o : current count; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i) begin
      cnt_o <= sat_inc(cnt_o);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Merges data-memory wait, mul/div occupancy of EX, taken-branch redirect and
// load-use hazards into per-stage register enables and flushes.
//   clk_i, rst_i                      : clock, synchronous active-high reset
//   id_rs1_i/id_rs2_i, *_used_i       : sources read by the ID instruction
//   ex_rd_i, ex_mem_read_i            : destination / load flag of the EX instruction
//   ex_md_valid_i, ex_md_is_div_i     : EX holds a mul/div (and which one)
//   branch_taken_i                    : EX resolved a taken branch/jump
//   mem_req_i, mem_ack_i              : MEM access outstanding / completing
//   pc_en_o .. mem_wb_en_o            : stage register enables
//   if_id_flush_o, id_ex_flush_o      : load a NOP into IF/ID, ID/EX
//   ex_mem_bubble_o                   : load a NOP into EX/MEM
//   md_start_o                        : one-cycle start pulse to the mul/div unit
//   stall_cycles_o, flush_count_o     : saturating performance counters
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_md_valid_i,
  input  logic             ex_md_is_div_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_bubble_o,
  output logic             md_start_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  localparam int MD_W = md_cnt_width(MUL_CYCLES, DIV_CYCLES);
  localparam logic [MD_W-1:0] MUL_LOAD = MD_W'(MUL_CYCLES - 1);
  localparam logic [MD_W-1:0] DIV_LOAD = MD_W'(DIV_CYCLES - 1);

  pipe_state_t     state_q, state_d;
  logic [MD_W-1:0] md_cnt_q, md_cnt_d;
  logic            freeze;
  logic            load_use;
  logic            flush_inc;
  logic            stall_inc;

  assign freeze = mem_req_i & ~mem_ack_i;

  // x0 is never written, so a load targeting it cannot create a hazard.
  assign load_use = ex_mem_read_i & (ex_rd_i != 5'd0) &
                    ((id_rs1_used_i & (ex_rd_i == id_rs1_i)) |
                     (id_rs2_used_i & (ex_rd_i == id_rs2_i)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    md_cnt_d        = md_cnt_q;
    pc_en_o         = 1'b1;
    if_id_en_o      = 1'b1;
    id_ex_en_o      = 1'b1;
    ex_mem_en_o     = 1'b1;
    mem_wb_en_o     = 1'b1;
    if_id_flush_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    ex_mem_bubble_o = 1'b0;
    md_start_o      = 1'b0;
    flush_inc       = 1'b0;

    if (rst_i) begin
      // Free-flowing pipe with no flushes while in reset; state clears on the edge.
    end else if (freeze) begin
      // Whole pipe holds, including the mul/div countdown.
      pc_en_o     = 1'b0;
      if_id_en_o  = 1'b0;
      id_ex_en_o  = 1'b0;
      ex_mem_en_o = 1'b0;
      mem_wb_en_o = 1'b0;
    end else if (state_q == MD_BUSY) begin
      if (md_cnt_q != '0) begin
        pc_en_o         = 1'b0;
        if_id_en_o      = 1'b0;
        id_ex_en_o      = 1'b0;
        ex_mem_bubble_o = 1'b1;
        md_cnt_d        = md_cnt_q - MD_W'(1);
      end else begin
        // Result is ready: everything advances and EX/MEM captures it.
        state_d = RUN;
      end
    end else if (branch_taken_i) begin
      // Branch outranks a simultaneous mul/div flag, so no start pulse here.
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      flush_inc     = 1'b1;
    end else if (ex_md_valid_i) begin
      md_start_o      = 1'b1;
      pc_en_o         = 1'b0;
      if_id_en_o      = 1'b0;
      id_ex_en_o      = 1'b0;
      ex_mem_bubble_o = 1'b1;
      md_cnt_d        = ex_md_is_div_i ? DIV_LOAD : MUL_LOAD;
      state_d         = MD_BUSY;
    end else if (load_use) begin
      // Hold IF/ID, push a bubble into EX; the load moves on to MEM.
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      id_ex_flush_o = 1'b1;
    end
  end

  assign stall_inc = ~pc_en_o;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cycles_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_inc),
    .cnt_o (flush_count_o)
  );

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It merges four sources into one set of per-stage enable and flush controls: data-memory wait, multi-cycle mul/div occupancy of EX, taken-branch redirect and load-use hazards. It owns the mul/div latency counter and the stall/flush performance counters. It sits beside the pipeline registers and drives their enables directly.

## Interface
Parameters:
- MUL_CYCLES, 3: EX occupancy of a multiply, in cycles; must be ≥1.
- DIV_CYCLES, 34: EX occupancy of a divide, in cycles; must be ≥1.
- CNT_W, 32: width of the performance counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- id_rs1_i, id_rs2_i  in  5  source registers of the instruction in ID.
- id_rs1_used_i, id_rs2_used_i  in  1  the ID instruction actually reads rs1/rs2.
- ex_rd_i  in  5  destination register of the instruction in EX.
- ex_mem_read_i  in  1  the EX instruction is a load.
- ex_md_valid_i  in  1  the EX instruction is a mul/div.
- ex_md_is_div_i  in  1  qualifies ex_md_valid_i: 1 = divide, 0 = multiply.
- branch_taken_i  in  1  a branch/jump resolved taken in EX.
- mem_req_i  in  1  the MEM stage holds a load/store.
- mem_ack_i  in  1  data memory completes the access this cycle.
- pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o  out  1  stage register enables.
- if_id_flush_o, id_ex_flush_o  out  1  load a NOP into IF/ID or ID/EX.
- ex_mem_bubble_o  out  1  load a NOP into EX/MEM instead of the EX result.
- md_start_o  out  1  single-cycle start pulse to the mul/div unit.
- stall_cycles_o, flush_count_o  out  CNT_W  performance counters.

## Operation
State machine (pipe_state_t):
- **RUN**: normal flow.
- **MD_BUSY**: EX is occupied by a mul/div. The internal counter md_cnt is ceil(log2(DIV_CYCLES)) bits wide.

Priority order, evaluated every cycle:
1. **Freeze.** Condition: mem_req_i & !mem_ack_i.
   - All five enables are 0; all flushes and the bubble are 0; md_start_o is 0.
   - State and md_cnt hold.
2. **MD_BUSY, md_cnt != 0.**
   - pc, if_id and id_ex enables are 0.
   - ex_mem_en_o is 1 with ex_mem_bubble_o = 1; mem_wb_en_o is 1.
   - md_cnt decrements.
3. **MD_BUSY, md_cnt == 0.**
   - All enables are 1, so the result is captured in EX/MEM.
   - Next state is RUN.
4. **RUN, branch_taken_i.**
   - All enables are 1; if_id_flush_o and id_ex_flush_o are both 1.
   - flush_count increments.
5. **RUN, ex_md_valid_i.**
   - md_start_o is 1. Enables and bubble are as in priority 2.
   - md_cnt is loaded with (ex_md_is_div_i ? DIV_CYCLES : MUL_CYCLES) − 1.
   - Next state is MD_BUSY.
6. **RUN, load-use.** Condition: ex_mem_read_i & ex_rd_i != 0 & ((id_rs1_used_i & ex_rd_i == id_rs1_i) | (id_rs2_used_i & ex_rd_i == id_rs2_i)).
   - pc_en_o and if_id_en_o are 0.
   - id_ex_flush_o is 1 and id_ex_en_o is 1, so a bubble goes to EX.
   - ex_mem and mem_wb enables are 1.
7. **Otherwise**: all enables 1, all flush/bubble/start outputs 0.

Rules and boundaries:
- Writes to x0 never create a load-use hazard.
- Branch and mul/div cannot both be valid, since they come from one EX instruction. If both are asserted, branch wins and md_start_o stays 0.
- stall_cycles increments every cycle with pc_en_o == 0.
- Both counters saturate at all-ones and never wrap.
- Freeze during MD_BUSY extends the total stall by the freeze length; md_cnt does not decrement while frozen.

## Timing
- All outputs are combinational from state, md_cnt and the inputs. Registers update on clk_i.
- While rst_i = 1:
  - All enables are 1.
  - if_id_flush_o, id_ex_flush_o, ex_mem_bubble_o and md_start_o are 0.
  - On the next edge: state = RUN, md_cnt = 0, both counters = 0.
- Reset mid-MD_BUSY aborts the operation; no md_start_o follows reset.
- Mul/div stall: with no freeze, EX stalls for exactly N = MUL_CYCLES or DIV_CYCLES cycles. The start cycle plus N−1 MD_BUSY cycles carry bubbles; the result advances in cycle N+1.
  - Case N = 1: one bubble cycle, then advance.
- Branch: one cycle of flush, zero stall.
- Load-use: exactly one stall cycle; the bubble clears the hazard.

## Structure
- Shared package cpu_pkg holds pipe_state_t {RUN, MD_BUSY}, MUL_CYCLES_DEF and DIV_CYCLES_DEF.
- One sub-module, sat_counter (parameter W; ports clk_i, rst_i, inc_i, cnt_o), instantiated twice for the performance counters.

## Test plan
- **Load-use.** ex_mem_read_i=1, ex_rd_i=5, id_rs1_i=5, id_rs1_used_i=1 → exactly one cycle of pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1; stall_cycles_o=1. Repeat with ex_rd_i=0 → no stall.
- **Divide.** ex_md_valid_i=1, ex_md_is_div_i=1, DIV_CYCLES=34 → md_start_o pulses once; pc_en_o=0 for 34 cycles with ex_mem_bubble_o=1; all enables 1 in cycle 35; state returns to RUN.
- **Freeze during multiply.** mem_req_i=1, mem_ack_i=0 held for 3 cycles during a MUL_CYCLES=3 multiply → all enables 0 for those cycles; total front-end stall = 6 cycles.
- **Branch.** branch_taken_i=1 together with a load-use condition → if_id_flush_o=id_ex_flush_o=1, pc_en_o=1, flush_count_o increments by 1, no stall.
- **Reset mid-divide.** Assert rst_i 10 cycles into a divide → next cycle state=RUN, counters=0, enables=1.
- **Saturation.** With CNT_W=4, 20 stall cycles → stall_cycles_o stays at 15.
